// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_t;

    localparam logic MST_INSTR = 1'b0;
    localparam logic MST_DATA  = 1'b1;

endpackage

// File: rtl/wb_arb_timeout.sv
// No-ack watchdog for one granted transfer; flags expiry on the last allowed cycle.
module wb_arb_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    input  logic ack,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run && !ack && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // A zero TIMEOUT_CYCLES disables expiry entirely; an ack in the same cycle wins.
    assign expired = (TIMEOUT_CYCLES != 0) && run && !ack && (cnt == LIMIT);

endmodule

// File: rtl/wb_dual_port_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave between an instruction and a data master.
module wb_dual_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  instr_cyc_i,
    input  logic                  instr_stb_i,
    input  logic                  instr_we_i,
    input  logic [ADDR_WIDTH-1:0] instr_addr_i,
    input  logic [DATA_WIDTH-1:0] instr_data_i,
    output logic [DATA_WIDTH-1:0] instr_data_o,
    output logic                  instr_ack_o,
    output logic                  instr_err_o,

    input  logic                  data_cyc_i,
    input  logic                  data_stb_i,
    input  logic                  data_we_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic [DATA_WIDTH-1:0] data_data_i,
    output logic [DATA_WIDTH-1:0] data_data_o,
    output logic                  data_ack_o,
    output logic                  data_err_o,

    output logic                  mem_cyc_o,
    output logic                  mem_stb_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic                  mem_ack_i
);

    arb_state_t state, state_nxt;
    logic       last_grant;
    logic       req_i, req_d;
    logic       in_idle, grant_i, grant_d;
    logic       gnt_cyc;
    logic       expired;

    assign req_i   = instr_cyc_i & instr_stb_i;
    assign req_d   = data_cyc_i & data_stb_i;
    assign in_idle = (state == IDLE);
    assign grant_i = (state == GRANT_I);
    assign grant_d = (state == GRANT_D);
    assign gnt_cyc = (grant_i & instr_cyc_i) | (grant_d & data_cyc_i);

    // Counter is held clear in IDLE, so every grant starts counting from zero.
    wb_arb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (in_idle),
        .run    (gnt_cyc),
        .ack    (mem_ack_i),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= MST_DATA;
        end else begin
            state <= state_nxt;
            if (in_idle && (state_nxt == GRANT_I)) last_grant <= MST_INSTR;
            if (in_idle && (state_nxt == GRANT_D)) last_grant <= MST_DATA;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_i && req_d) begin
                    state_nxt = (last_grant == MST_INSTR) ? GRANT_D : GRANT_I;
                end else if (req_i) begin
                    state_nxt = GRANT_I;
                end else if (req_d) begin
                    state_nxt = GRANT_D;
                end
            end
            GRANT_I, GRANT_D: begin
                // One transfer per grant: ack, abort or timeout all end it.
                if (!gnt_cyc || mem_ack_i || expired) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_cyc_o    = 1'b0;
        mem_stb_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        instr_data_o = '0;
        instr_ack_o  = 1'b0;
        instr_err_o  = 1'b0;
        data_data_o  = '0;
        data_ack_o   = 1'b0;
        data_err_o   = 1'b0;
        if (grant_i) begin
            mem_cyc_o    = instr_cyc_i & ~expired;
            mem_stb_o    = instr_stb_i & ~expired;
            mem_we_o     = instr_we_i;
            mem_addr_o   = instr_addr_i;
            mem_data_o   = instr_data_i;
            instr_data_o = mem_data_i;
            instr_ack_o  = mem_ack_i;
            instr_err_o  = expired;
        end else if (grant_d) begin
            mem_cyc_o    = data_cyc_i & ~expired;
            mem_stb_o    = data_stb_i & ~expired;
            mem_we_o     = data_we_i;
            mem_addr_o   = data_addr_i;
            mem_data_o   = data_data_i;
            data_data_o  = mem_data_i;
            data_ack_o   = mem_ack_i;
            data_err_o   = expired;
        end
    end

endmodule

// File: tb/tb_wb_dual_port_arbiter.sv
// Directed bench for wb_dual_port_arbiter with an 8-cycle timeout.
module tb_wb_dual_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          instr_cyc, instr_stb, instr_we;
    logic [AW-1:0] instr_addr;
    logic [DW-1:0] instr_wdat, instr_rdat;
    logic          instr_ack, instr_err;
    logic          data_cyc, data_stb, data_we;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdat, data_rdat;
    logic          data_ack, data_err;
    logic          mem_cyc, mem_stb, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdat, mem_rdat;
    logic          mem_ack;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    wb_dual_port_arbiter #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_cyc_i (instr_cyc),
        .instr_stb_i (instr_stb),
        .instr_we_i  (instr_we),
        .instr_addr_i(instr_addr),
        .instr_data_i(instr_wdat),
        .instr_data_o(instr_rdat),
        .instr_ack_o (instr_ack),
        .instr_err_o (instr_err),
        .data_cyc_i  (data_cyc),
        .data_stb_i  (data_stb),
        .data_we_i   (data_we),
        .data_addr_i (data_addr),
        .data_data_i (data_wdat),
        .data_data_o (data_rdat),
        .data_ack_o  (data_ack),
        .data_err_o  (data_err),
        .mem_cyc_o   (mem_cyc),
        .mem_stb_o   (mem_stb),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_data_o  (mem_wdat),
        .mem_data_i  (mem_rdat),
        .mem_ack_i   (mem_ack)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    endtask

    task automatic clear_inputs();
        instr_cyc = 0; instr_stb = 0; instr_we = 0; instr_addr = '0; instr_wdat = '0;
        data_cyc  = 0; data_stb  = 0; data_we  = 0; data_addr  = '0; data_wdat  = '0;
        mem_ack   = 0; mem_rdat  = '0;
    endtask

    task automatic req_instr(input logic [AW-1:0] a);
        instr_cyc = 1; instr_stb = 1; instr_we = 0; instr_addr = a;
    endtask

    task automatic req_data(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] d);
        data_cyc = 1; data_stb = 1; data_we = we; data_addr = a; data_wdat = d;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    int errs;

    initial begin
        clear_inputs();
        rst_n = 0;
        // Reset: requests and an ack present must not reach any output
        req_instr(32'h0000_0100);
        instr_wdat = 32'h1234_5678;
        mem_ack = 1; mem_rdat = 32'hDEAD_BEEF;
        @(negedge clk); #1;
        chk("rst_mem_ctl", {mem_cyc, mem_stb, mem_we}, 3'b000);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdat", mem_wdat, 0);
        chk("rst_acks", {instr_ack, instr_err, data_ack, data_err}, 4'b0000);
        chk("rst_rdat", {instr_rdat, data_rdat}, 0);
        @(negedge clk);
        clear_inputs();
        rst_n = 1;

        // Ack while idle is ignored
        @(negedge clk);
        mem_ack = 1; mem_rdat = 32'h55;
        #1;
        chk("idle_ack", {instr_ack, data_ack}, 2'b00);
        chk("idle_rdat", instr_rdat, 0);

        // Instr-only read, slave acks in the second grant cycle
        @(negedge clk);
        clear_inputs();
        req_instr(32'h0000_0100);
        #1;
        chk("rd_pre_grant_cyc", mem_cyc, 0);
        @(negedge clk); #1;
        chk("rd_grant_cyc", {mem_cyc, mem_stb, mem_we}, 3'b110);
        chk("rd_addr", mem_addr, 32'h0000_0100);
        chk("rd_no_ack_yet", instr_ack, 0);
        @(negedge clk);
        mem_ack = 1; mem_rdat = 32'h0000_0013;
        #1;
        chk("rd_ack", {instr_ack, data_ack}, 2'b10);
        chk("rd_data", instr_rdat, 32'h0000_0013);
        @(negedge clk);
        clear_inputs();
        mem_ack = 1;
        #1;
        chk("rd_ack_one_cycle", instr_ack, 0);
        @(negedge clk);
        clear_inputs();

        // Round robin after reset: instr, bubble, data, bubble, instr
        reset_pulse();
        req_instr(32'h0000_0100);
        req_data(32'h0000_0200, 0, '0);
        @(negedge clk);
        mem_ack = 1; mem_rdat = 32'hA1;
        #1;
        chk("rr1_addr", mem_addr, 32'h0000_0100);
        chk("rr1_ack", {instr_ack, data_ack}, 2'b10);
        @(negedge clk);
        mem_ack = 0;
        instr_addr = 32'h0000_0104;
        #1;
        chk("rr_bubble1", mem_cyc, 0);
        @(negedge clk);
        mem_ack = 1; mem_rdat = 32'hD2;
        #1;
        chk("rr2_addr", mem_addr, 32'h0000_0200);
        chk("rr2_ack", {instr_ack, data_ack}, 2'b01);
        chk("rr2_data", data_rdat, 32'hD2);
        @(negedge clk);
        mem_ack = 0;
        data_cyc = 0; data_stb = 0;
        #1;
        chk("rr_bubble2", mem_cyc, 0);
        @(negedge clk);
        mem_ack = 1;
        #1;
        chk("rr3_addr", mem_addr, 32'h0000_0104);
        chk("rr3_ack", {instr_ack, data_ack}, 2'b10);
        @(negedge clk);
        clear_inputs();

        // Data write
        @(negedge clk);
        req_data(32'h8000_0004, 1, 32'hCAFE_BABE);
        @(negedge clk); #1;
        chk("wr_ctl", {mem_cyc, mem_stb, mem_we}, 3'b111);
        chk("wr_addr", mem_addr, 32'h8000_0004);
        chk("wr_wdat", mem_wdat, 32'hCAFE_BABE);
        mem_ack = 1;
        #1;
        chk("wr_ack", {instr_ack, data_ack}, 2'b01);
        @(negedge clk);
        clear_inputs();

        // Abort: master drops cyc before ack, late ack goes nowhere
        @(negedge clk);
        req_instr(32'h0000_0500);
        @(negedge clk); #1;
        chk("abort_granted", mem_cyc, 1);
        instr_cyc = 0; instr_stb = 0;
        #1;
        chk("abort_cyc_follows", {mem_cyc, instr_err}, 2'b00);
        @(negedge clk);
        mem_ack = 1;
        #1;
        chk("abort_late_ack", {instr_ack, instr_err}, 2'b00);
        @(negedge clk);
        clear_inputs();

        // Timeout: data slave never acks, err in the 8th grant cycle
        @(negedge clk);
        req_data(32'h0000_0300, 0, '0);
        errs = 0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk); #1;
            if (data_err || !mem_cyc) errs++;
        end
        chk("to_early_err", errs, 0);
        @(negedge clk); #1;
        chk("to_err", {data_err, instr_err}, 2'b10);
        chk("to_cyc_forced", {mem_cyc, mem_stb}, 2'b00);
        data_cyc = 0; data_stb = 0;
        @(negedge clk); #1;
        chk("to_idle", {mem_cyc, data_err}, 2'b00);

        // Ack coinciding with the timeout cycle wins
        @(negedge clk);
        req_instr(32'h0000_0600);
        for (int k = 1; k <= 7; k++) @(negedge clk);
        @(negedge clk);
        mem_ack = 1;
        #1;
        chk("to_ack_wins", {instr_ack, instr_err}, 2'b10);
        @(negedge clk);
        clear_inputs();

        // Reset mid-grant, then a pending instr request is served
        @(negedge clk);
        req_instr(32'h0000_0400);
        @(negedge clk); #1;
        chk("mid_rst_granted", mem_cyc, 1);
        rst_n = 0;
        mem_ack = 1; mem_rdat = 32'h99;
        #1;
        chk("mid_rst_ctl", {mem_cyc, mem_stb, mem_addr}, 0);
        chk("mid_rst_acks", {instr_ack, instr_err, instr_rdat}, 0);
        @(negedge clk);
        mem_ack = 0;
        rst_n = 1;
        @(negedge clk); #1;
        chk("post_rst_grant", {mem_cyc, mem_addr}, {1'b1, 32'h0000_0400});
        mem_ack = 1; mem_rdat = 32'h77;
        #1;
        chk("post_rst_ack", {instr_ack, instr_rdat}, {1'b1, 32'h77});
        @(negedge clk);
        clear_inputs();
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
